// File: rtl/seg_scan_mux.sv
// Purpose: two-digit time-multiplexed segment driver with dead-time and optional leading-zero blanking.
// Latency: a load at edge k is visible on seg_out from cycle k+1 if that digit is lit; outputs decode state directly.
// Backpressure: none; load is accepted on every edge and never stalls the scan.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   in_seg1, in_seg2  - tens / ones codes (active-high abcdefg), captured together on load
//   load              - capture strobe for both codes
//   blank_lead        - blank the tens digit while it shows ZERO_CODE (not latched)
//   seg_out           - shared segment bus, polarity set by SEG_ACTIVE_LOW
//   an                - digit enables, active-low; bit 1 = tens, bit 0 = ones
//   frame_tick        - one-cycle pulse in the last cycle of each full scan
module seg_scan_mux #(
    parameter int unsigned REFRESH_DIV    = 4,
    parameter int unsigned DEAD_CYC       = 1,
    parameter logic [6:0]  ZERO_CODE      = 7'h3F,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] in_seg1,
    input  logic [6:0] in_seg2,
    input  logic       load,
    input  logic       blank_lead,
    output logic [6:0] seg_out,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int unsigned MAX_RD  = (REFRESH_DIV > DEAD_CYC) ? REFRESH_DIV : DEAD_CYC;
    localparam int unsigned MAX_LEN = (MAX_RD > 1) ? MAX_RD : 1;
    // A one-cycle phase still needs a 1-bit counter to keep the width legal.
    localparam int unsigned CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CW-1:0] SHOW_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'((DEAD_CYC > 0) ? (DEAD_CYC - 1) : 0);

    typedef enum logic [1:0] {
        SHOW1 = 2'd0,
        DEAD1 = 2'd1,
        SHOW2 = 2'd2,
        DEAD2 = 2'd3
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [6:0]    sh1, sh2;
    logic          phase_last;
    logic          lead_blank;
    logic [6:0]    code;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SHOW1;
            cnt   <= '0;
            sh1   <= 7'h00;
            sh2   <= 7'h00;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            // Both shadows update on the same edge so a digit pair never tears.
            if (load) begin
                sh1 <= in_seg1;
                sh2 <= in_seg2;
            end
        end
    end

    // Sequencing: each phase runs its length, then the counter clears.
    // With no dead time the dead phases are bypassed entirely.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + 1'b1;
        phase_last = 1'b0;
        frame_tick = 1'b0;
        case (state)
            SHOW1: begin
                phase_last = (cnt == SHOW_LAST);
                if (phase_last) state_d = (DEAD_CYC == 0) ? SHOW2 : DEAD1;
            end
            DEAD1: begin
                phase_last = (cnt == DEAD_LAST);
                if (phase_last) state_d = SHOW2;
            end
            SHOW2: begin
                phase_last = (cnt == SHOW_LAST);
                if (phase_last) state_d = (DEAD_CYC == 0) ? SHOW1 : DEAD2;
                frame_tick = phase_last && (DEAD_CYC == 0);
            end
            DEAD2: begin
                phase_last = (cnt == DEAD_LAST);
                if (phase_last) state_d = SHOW1;
                frame_tick = phase_last;
            end
            default: state_d = SHOW1;
        endcase
        if (phase_last) cnt_d = '0;
    end

    // Tens digit blanks only when it would show zero and blanking is requested now.
    assign lead_blank = blank_lead && (sh1 == ZERO_CODE);

    always_comb begin
        an   = 2'b11;
        code = 7'h00;
        case (state)
            SHOW1: begin
                if (!lead_blank) begin
                    an   = 2'b01;
                    code = sh1;
                end
            end
            SHOW2: begin
                an   = 2'b10;
                code = sh2;
            end
            default: begin
                an   = 2'b11;
                code = 7'h00;
            end
        endcase
    end

    assign seg_out = SEG_ACTIVE_LOW ? ~code : code;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Purpose: bench for seg_scan_mux, default build plus a no-dead-time build sharing inputs.
// Latency: model tracks cycles since reset; outputs compared each negedge, literal checks at posedge+3.
// Backpressure: n/a.
module tb_seg_scan_mux;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_seg1, in_seg2;
    logic       load, blank_lead;
    logic [6:0] seg_out, seg_out_nd;
    logic [1:0] an, an_nd;
    logic       frame_tick, frame_tick_nd;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seg_scan_mux dut (
        .clk(clk), .rst(rst), .in_seg1(in_seg1), .in_seg2(in_seg2),
        .load(load), .blank_lead(blank_lead),
        .seg_out(seg_out), .an(an), .frame_tick(frame_tick)
    );

    seg_scan_mux #(.REFRESH_DIV(2), .DEAD_CYC(0)) dut_nd (
        .clk(clk), .rst(rst), .in_seg1(in_seg1), .in_seg2(in_seg2),
        .load(load), .blank_lead(blank_lead),
        .seg_out(seg_out_nd), .an(an_nd), .frame_tick(frame_tick_nd)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: cycles since reset and the captured codes; the display follows from position in the frame.
    int         t = 0;
    bit         model_ok = 1'b0;
    logic [6:0] m1 = 7'h00, m2 = 7'h00;

    always @(posedge clk) begin
        if (rst) begin
            t = 0; m1 = 7'h00; m2 = 7'h00; model_ok = 1'b1;
        end else begin
            t = t + 1;
            if (load) begin m1 = in_seg1; m2 = in_seg2; end
        end
    end

    function automatic void expect_out(input int tc, input int r, input int d,
                                       output logic [1:0] e_an, output logic [6:0] e_seg,
                                       output logic e_ft);
        int p, ph;
        logic [6:0] c;
        p  = 2 * (r + d);
        ph = tc % p;
        c  = 7'h00;
        e_an = 2'b11;
        if (ph < r) begin
            if (!(blank_lead && m1 == 7'h3F)) begin e_an = 2'b01; c = m1; end
        end else if (ph >= r + d && ph < 2 * r + d) begin
            e_an = 2'b10; c = m2;
        end
        e_seg = ~c;
        e_ft  = (ph == p - 1);
    endfunction

    always @(negedge clk) begin
        logic [1:0] ea;
        logic [6:0] es;
        logic       ef;
        if (model_ok) begin
            expect_out(t, 4, 1, ea, es, ef);
            chk("model_an", 32'(an), 32'(ea));
            chk("model_seg", 32'(seg_out), 32'(es));
            chk("model_tick", 32'(frame_tick), 32'(ef));
            chk("an_not_both_low", 32'(an == 2'b00), 32'd0);
            expect_out(t, 2, 0, ea, es, ef);
            chk("nd_model_an", 32'(an_nd), 32'(ea));
            chk("nd_model_seg", 32'(seg_out_nd), 32'(es));
            chk("nd_model_tick", 32'(frame_tick_nd), 32'(ef));
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #3;
        end
    endtask

    initial begin
        logic [1:0] an_seq [0:9];
        an_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11};

        rst = 1'b1; in_seg1 = 7'h11; in_seg2 = 7'h22; load = 1'b1; blank_lead = 1'b0;
        step(2);
        chk("rst_an", 32'(an), 32'h1);
        chk("rst_seg", 32'(seg_out), 32'h7F);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        rst = 1'b0; load = 1'b0;

        // Cycle 0 is the state left by the last reset edge.
        for (int i = 0; i < 10; i++) begin
            if (i > 0) step(1);
            chk("seq_an", 32'(an), 32'(an_seq[i]));
            chk("seq_tick", 32'(frame_tick), 32'(i == 9));
            chk("seq_seg_blank", 32'(seg_out), 32'h7F);
            chk("nd_seq_an", 32'(an_nd), (i % 4 < 2) ? 32'h1 : 32'h2);
            chk("nd_seq_tick", 32'(frame_tick_nd), 32'(i % 4 == 3));
        end

        // Value 15, loaded at the edge that starts cycle 0.
        in_seg1 = 7'h06; in_seg2 = 7'h6D; load = 1'b1;
        step(1);
        load = 1'b0;
        chk("v15_show1_seg", 32'(seg_out), 32'h79);
        step(4);
        chk("v15_dead1_seg", 32'(seg_out), 32'h7F);
        step(1);
        chk("v15_show2_seg", 32'(seg_out), 32'h12);

        // Leading zero, loaded during cycle 5.
        in_seg1 = 7'h3F; in_seg2 = 7'h07; load = 1'b1; blank_lead = 1'b1;
        step(1);
        load = 1'b0;
        chk("lz_show2_seg", 32'(seg_out), 32'h78);
        step(4);
        chk("lz_show1_an", 32'(an), 32'h3);
        chk("lz_show1_seg", 32'(seg_out), 32'h7F);
        blank_lead = 1'b0;
        #1;
        chk("lz_off_seg", 32'(seg_out), 32'h40);
        chk("lz_off_an", 32'(an), 32'h1);

        // Mid-phase load during SHOW2 cycle 2 (frame cycle 7).
        step(7);
        in_seg2 = 7'h5B; load = 1'b1;
        chk("mid_before_seg", 32'(seg_out), 32'h78);
        step(1);
        load = 1'b0;
        chk("mid_after_seg", 32'(seg_out), 32'h24);
        chk("mid_after_an", 32'(an), 32'h2);
        step(1);
        chk("mid_dead2_an", 32'(an), 32'h3);
        chk("mid_dead2_tick", 32'(frame_tick), 32'h1);
        step(1);
        chk("mid_wrap_an", 32'(an), 32'h1);

        // Reset during SHOW2 cycle 1 (frame cycle 6).
        step(6);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("mrst_an", 32'(an), 32'h1);
        chk("mrst_seg", 32'(seg_out), 32'h7F);
        chk("mrst_tick", 32'(frame_tick), 32'h0);
        step(4);
        chk("mrst_dead1_an", 32'(an), 32'h3);
        step(5);
        chk("mrst_tick9", 32'(frame_tick), 32'h1);

        step(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
